// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: streams a bitstream into a serial ccff chain,
// recirculates the chain once to read it back, and compares CRC-8 signatures
// of the bits sent and the bits returned to decide done or error.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 8,
  parameter int DATA_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_err
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LEN_C    = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_COMPARE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [BW-1:0]     buf_cnt_q, buf_cnt_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]     chk_cnt_q, chk_cnt_d;
  logic [7:0]        crc_in_q, crc_in_d;
  logic [7:0]        crc_out_q, crc_out_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [CW-1:0]     remaining;
  logic [BW-1:0]     take;
  logic [DATA_W-1:0] take_mask;

  // One step of the bit-serial CRC-8, polynomial x^8+x^2+x+1.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  // Size of the next word: all of it, or only the bits the chain still needs.
  always_comb begin
    remaining = LEN_C - bit_cnt_q;
    if (32'(remaining) >= 32'(DATA_W)) begin
      take = BW'(DATA_W);
    end else begin
      take = BW'(remaining);
    end
    take_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      take_mask[i] = (i < int'(take));
    end
  end

  // Next-state and output logic; abort overrides whatever the busy states decided.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    buf_cnt_d   = buf_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    chk_cnt_d   = chk_cnt_q;
    crc_in_d    = crc_in_q;
    crc_out_d   = crc_out_q;
    done_d      = done_q;
    err_d       = err_q;
    cfg_ready   = 1'b0;
    ccff_head   = 1'b0;
    ccff_clk_en = 1'b0;
    busy        = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d   = S_LOAD;
          buf_d     = '0;
          buf_cnt_d = '0;
          bit_cnt_d = '0;
          chk_cnt_d = '0;
          crc_in_d  = '0;
          crc_out_d = '0;
          done_d    = 1'b0;
          err_d     = 1'b0;
        end
      end

      S_LOAD: begin
        busy = 1'b1;
        if (buf_cnt_q != '0) begin
          ccff_clk_en = 1'b1;
          ccff_head   = buf_q[0];
          buf_d       = buf_q >> 1;
          buf_cnt_d   = buf_cnt_q - BW'(1);
          bit_cnt_d   = bit_cnt_q + CW'(1);
          crc_in_d    = crc8_step(crc_in_q, buf_q[0]);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = S_CHECK;
          end
        end else if (remaining != '0) begin
          cfg_ready = 1'b1;
          if (cfg_valid) begin
            buf_d     = cfg_data & take_mask;
            buf_cnt_d = take;
          end
        end
      end

      S_CHECK: begin
        busy        = 1'b1;
        ccff_clk_en = 1'b1;
        ccff_head   = ccff_tail;
        crc_out_d   = crc8_step(crc_out_q, ccff_tail);
        chk_cnt_d   = chk_cnt_q + CW'(1);
        if (chk_cnt_q == LAST_BIT) begin
          state_d = S_COMPARE;
        end
      end

      S_COMPARE: begin
        busy = 1'b1;
        if (crc_out_q == crc_in_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (busy && abort) begin
      state_d   = S_ERROR;
      err_d     = 1'b1;
      done_d    = 1'b0;
      buf_d     = '0;
      buf_cnt_d = '0;
    end
  end

  // State and datapath registers, cleared immediately by reset.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q   <= S_IDLE;
      buf_q     <= '0;
      buf_cnt_q <= '0;
      bit_cnt_q <= '0;
      chk_cnt_q <= '0;
      crc_in_q  <= '0;
      crc_out_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      buf_cnt_q <= buf_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      chk_cnt_q <= chk_cnt_d;
      crc_in_q  <= crc_in_d;
      crc_out_q <= crc_out_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign cfg_done = done_q;
  assign cfg_err  = err_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: two instances (8-bit and 12-bit chains) each
// driving a behavioural shift-register chain, checked against a word-level model.
module tb_ccff_chain_loader;

  logic       prog_clk     = 1'b0;
  logic       prog_reset_n = 1'b1;
  logic       start        = 1'b0;
  logic       abort        = 1'b0;
  logic       cfg_valid    = 1'b0;
  logic [7:0] cfg_data     = 8'h00;
  logic       sel          = 1'b0;
  logic       stuck        = 1'b0;

  logic ready8, head8, en8, busy8, done8, err8, tail8;
  logic ready12, head12, en12, busy12, done12, err12, tail12;
  logic [7:0]  chain8  = 8'h00;
  logic [11:0] chain12 = 12'h000;

  logic o_ready, o_head, o_clk_en, o_busy, o_done, o_err;

  int n_vec = 0;
  int n_err = 0;

  bit [7:0] words_q[$];
  int       gaps_q[$];
  bit       got_q[$];

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.CHAIN_LEN(8), .DATA_W(8)) u_dut8 (
    .prog_clk    (prog_clk),
    .prog_reset_n(prog_reset_n),
    .start       (start && !sel),
    .abort       (abort && !sel),
    .cfg_data    (cfg_data),
    .cfg_valid   (cfg_valid && !sel),
    .cfg_ready   (ready8),
    .ccff_head   (head8),
    .ccff_clk_en (en8),
    .ccff_tail   (tail8),
    .busy        (busy8),
    .cfg_done    (done8),
    .cfg_err     (err8)
  );

  ccff_chain_loader #(.CHAIN_LEN(12), .DATA_W(8)) u_dut12 (
    .prog_clk    (prog_clk),
    .prog_reset_n(prog_reset_n),
    .start       (start && sel),
    .abort       (abort && sel),
    .cfg_data    (cfg_data),
    .cfg_valid   (cfg_valid && sel),
    .cfg_ready   (ready12),
    .ccff_head   (head12),
    .ccff_clk_en (en12),
    .ccff_tail   (tail12),
    .busy        (busy12),
    .cfg_done    (done12),
    .cfg_err     (err12)
  );

  // Physical chains: new bit enters at the MSB, tail is bit 0.
  always @(posedge prog_clk) if (en8)  chain8  <= {head8, chain8[7:1]};
  always @(posedge prog_clk) if (en12) chain12 <= {head12, chain12[11:1]};

  assign tail8  = (stuck && !sel) ? 1'b0 : chain8[0];
  assign tail12 = (stuck && sel)  ? 1'b0 : chain12[0];

  assign o_ready  = sel ? ready12 : ready8;
  assign o_head   = sel ? head12  : head8;
  assign o_clk_en = sel ? en12    : en8;
  assign o_busy   = sel ? busy12  : busy8;
  assign o_done   = sel ? done12  : done8;
  assign o_err    = sel ? err12   : err8;

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // CRC-8 as the remainder of message*x^8 divided by 0x107, first bit highest degree.
  function automatic logic [7:0] crc_of(input bit b[$]);
    logic [39:0] v;
    int n;
    v = '0;
    n = b.size();
    for (int i = 0; i < n; i++) v[n - 1 - i + 8] = b[i];
    for (int d = n + 7; d >= 8; d--) if (v[d]) v = v ^ (40'h107 << (d - 8));
    return v[7:0];
  endfunction

  // Runs one full load on the selected instance and checks it against the model.
  task automatic apply_stimulus(input string tag, input int reset_after);
    bit          exp_bits[$];
    bit          chk_bits[$];
    logic [11:0] exp_chain, eb, ec, lb, cb, obs_chain;
    bit          exp_done, accepted, hit_reset, finished;
    int          len, used, n, en_cnt, budget, wait_cnt, late_ready, stall_bad;

    len       = sel ? 12 : 8;
    used      = 0;
    exp_chain = '0;
    foreach (words_q[w]) begin
      n = (len - used < 8) ? len - used : 8;
      for (int i = 0; i < n; i++) begin
        exp_bits.push_back(words_q[w][i]);
        exp_chain[used + i] = words_q[w][i];
      end
      used += n;
    end
    for (int i = 0; i < len; i++) chk_bits.push_back(stuck ? 1'b0 : exp_bits[i]);
    exp_done = (crc_of(exp_bits) == crc_of(chk_bits));
    if (stuck) exp_chain = '0;

    start = 1'b1;
    tick();
    start = 1'b0;
    en_cnt = 0; budget = 0; wait_cnt = 0; late_ready = 0; stall_bad = 0;
    hit_reset = 0; finished = 0;
    got_q.delete();
    while (budget < 400) begin
      budget++;
      if (!o_busy) begin
        finished = 1;
        break;
      end
      if (reset_after > 0 && en_cnt == len + reset_after) begin
        #3;
        prog_reset_n = 1'b0;
        #1;
        check_output({tag, "_outs_in_reset"},
                     {26'b0, o_ready, o_head, o_clk_en, o_busy, o_done, o_err}, 32'h0);
        hit_reset = 1;
        break;
      end
      if (o_clk_en) begin
        got_q.push_back(o_head);
        en_cnt++;
      end
      accepted  = 0;
      cfg_valid = 1'b0;
      if (o_ready) begin
        if (words_q.size() == 0) late_ready++;
        else if (wait_cnt < gaps_q[0]) begin
          wait_cnt++;
          if (o_clk_en) stall_bad++;
        end else begin
          cfg_valid = 1'b1;
          cfg_data  = words_q[0];
          accepted  = 1;
        end
      end
      tick();
      if (accepted) begin
        void'(words_q.pop_front());
        void'(gaps_q.pop_front());
        wait_cnt = 0;
      end
    end
    cfg_valid = 1'b0;
    if (hit_reset) return;

    check_output({tag, "_finished"}, 32'(finished), 32'h1);
    eb = '0; ec = '0; lb = '0; cb = '0;
    for (int i = 0; i < len; i++) begin
      eb[i] = exp_bits[i];
      ec[i] = chk_bits[i];
      if (i < got_q.size())       lb[i] = got_q[i];
      if (len + i < got_q.size()) cb[i] = got_q[len + i];
    end
    obs_chain = sel ? chain12 : {4'b0, chain8};
    check_output({tag, "_shift_count"}, 32'(en_cnt), 32'(2 * len));
    check_output({tag, "_load_bits"}, 32'(lb), 32'(eb));
    check_output({tag, "_check_bits"}, 32'(cb), 32'(ec));
    check_output({tag, "_done"}, 32'(o_done), 32'(exp_done));
    check_output({tag, "_err"}, 32'(o_err), 32'(!exp_done));
    check_output({tag, "_chain"}, 32'(obs_chain), 32'(exp_chain));
    check_output({tag, "_late_ready"}, 32'(late_ready), 32'h0);
    check_output({tag, "_stall_clk_en"}, 32'(stall_bad), 32'h0);
  endtask

  initial begin : main
    logic [11:0] saved_chain;
    logic        saved_done;
    int          cnt, b;

    #2 prog_reset_n = 1'b0;
    #10;
    check_output("reset_outs_both",
                 {20'b0, ready8, head8, en8, busy8, done8, err8,
                  ready12, head12, en12, busy12, done12, err12}, 32'h0);
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
    tick();
    tick();
    check_output("idle_after_reset", {27'b0, o_busy, o_clk_en, o_ready, o_done, o_err}, 32'h0);

    $display("[TB] basic load 0xA5 on 8-bit chain");
    sel = 1'b0; stuck = 1'b0;
    words_q = '{8'hA5}; gaps_q = '{0};
    apply_stimulus("basic", 0);
    check_output("basic_chain_a5", 32'(chain8), 32'hA5);

    $display("[TB] partial last word on 12-bit chain");
    sel = 1'b1;
    words_q = '{8'h3C, 8'hFF}; gaps_q = '{0, 0};
    apply_stimulus("partial", 0);
    check_output("partial_chain_f3c", 32'(chain12), 32'hF3C);
    saved_chain = chain12;
    saved_done  = done12;

    $display("[TB] five-cycle stall between words");
    words_q = '{8'h3C, 8'hFF}; gaps_q = '{0, 5};
    apply_stimulus("stall", 0);
    check_output("stall_chain_same", 32'(chain12), 32'(saved_chain));
    check_output("stall_done_same", 32'(done12), 32'(saved_done));

    $display("[TB] stuck-at-0 tail fault");
    sel = 1'b0; stuck = 1'b1;
    words_q = '{8'hFF}; gaps_q = '{0};
    apply_stimulus("fault", 0);
    check_output("fault_err", 32'(o_err), 32'h1);
    check_output("fault_done", 32'(o_done), 32'h0);
    stuck = 1'b0;

    $display("[TB] abort after three shifts");
    start = 1'b1;
    tick();
    start = 1'b0;
    b = 0;
    while (!o_ready && b < 20) begin
      tick();
      b++;
    end
    cfg_valid = 1'b1;
    cfg_data  = 8'hC3;
    tick();
    cfg_valid = 1'b0;
    cnt = 0; b = 0;
    while (cnt < 3 && b < 50) begin
      if (o_clk_en) cnt++;
      tick();
      b++;
    end
    check_output("abort_shifts_seen", 32'(cnt), 32'h3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("abort_state", {27'b0, o_busy, o_clk_en, o_ready, o_done, o_err}, 32'h01);
    words_q = '{8'h5A}; gaps_q = '{0};
    apply_stimulus("restart", 0);
    check_output("restart_chain_5a", 32'(chain8), 32'h5A);

    $display("[TB] asynchronous reset during CHECK");
    words_q = '{8'h96}; gaps_q = '{0};
    apply_stimulus("rstchk", 3);
    tick();
    check_output("reset_held_outs", {27'b0, o_busy, o_clk_en, o_ready, o_done, o_err}, 32'h0);
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_output("stays_idle", {27'b0, o_busy, o_clk_en, o_ready, o_done, o_err}, 32'h0);

    $display("[TB] randomized loads on 12-bit chain");
    sel = 1'b1;
    for (int k = 0; k < 6; k++) begin
      stuck   = ($urandom_range(0, 3) == 0);
      words_q = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      gaps_q  = '{int'($urandom_range(0, 3)), int'($urandom_range(0, 3))};
      apply_stimulus($sformatf("rand%0d", k), 0);
    end
    stuck = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
